sad_search_ctrl: RTL and testbench
==================================

Name: sad_search_ctrl

Overview:
Sequencer for the dual 256-entry byte FIFO in the full-search SAD motion estimator.
- Loads the 16x16 current block into FIFO 1 once per search.
- For each candidate position it loads the reference block into FIFO 2. It then drains both FIFOs in lockstep, accumulating |cur-ref|, and recirculates current pixels back into FIFO 1.
- Tracks the minimum SAD and its motion vector and reports them when the search completes.

Parameters:
P, 1, search range; positions dy,dx in -P..+P, raster order (dy outer, dx inner), N_POS=(2P+1)^2
BLK_PIX, 256, pixels per block (must equal FIFO depth)
MV_W, 5, signed motion-vector component width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin search; ignored unless IDLE
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse, results valid
err  out  1  one-cycle pulse: start seen with non-empty FIFO
cur_pix  in  8  current-block pixel
cur_valid  in  1  cur_pix valid
cur_ready  out  1  controller accepts cur_pix
ref_pix  in  8  reference pixel for current position
ref_valid  in  1  ref_pix valid
ref_ready  out  1  controller accepts ref_pix
fifo_din_1  out  8  FIFO 1 write data
fifo_wr_1  out  1  FIFO 1 write strobe
fifo_rd_1  out  1  FIFO 1 read strobe
fifo_dout_1  in  8  FIFO 1 read data, registered, valid 1 cycle after rd
fifo_count_1  in  9  FIFO 1 occupancy
fifo_din_2  out  8  FIFO 2 write data
fifo_wr_2  out  1  FIFO 2 write strobe
fifo_rd_2  out  1  FIFO 2 read strobe
fifo_dout_2  in  8  FIFO 2 read data, registered
fifo_count_2  in  9  FIFO 2 occupancy
best_sad  out  16  minimum SAD found
best_mv_x  out  MV_W  signed dx of best position
best_mv_y  out  MV_W  signed dy of best position

Behaviour:
Reset and clocking:
- Reset rst, synchronous, active-high; clock clk.
- Reset: state IDLE; all outputs 0, including strobes, ready, best_sad and mv.
- The FIFO shares rst. A reset mid-operation aborts the search with no done pulse.

FSM states: IDLE, LOAD_CUR, LOAD_REF, DRAIN, CMP, DONE.
- IDLE:
  - On start with fifo_count_1==0 and fifo_count_2==0: best_sad<=16'hFFFF, position<=(-P,-P), busy<=1, go to LOAD_CUR.
  - If start arrives and either count is nonzero: err pulse, stay IDLE.
- LOAD_CUR:
  - cur_ready=1; fifo_wr_1=cur_valid; fifo_din_1=cur_pix (combinational).
  - After 256 handshakes, go to LOAD_REF.
  - Stalls are unbounded; an internal 9-bit counter is used, never the FIFO flags, because those lag by a register.
- LOAD_REF: same as LOAD_CUR using ref_* and FIFO 2; 256 handshakes, then DRAIN.
- DRAIN, 257 cycles:
  - Cycles 0..255: fifo_rd_1=fifo_rd_2=1.
  - rd_q = rd delayed 1 cycle. When rd_q=1: sad_acc += |fifo_dout_1-fifo_dout_2|, and fifo_wr_1=1 with fifo_din_1=fifo_dout_1 (recirculation).
  - sad_acc clears on DRAIN entry.
  - Cycle 256 is the tail: rd=0, rd_q=1.
  - Exit: FIFO 1 count back to 256; FIFO 2 at 0.
- CMP, 1 cycle:
  - If sad_acc < best_sad (strict, so the earliest position wins ties), update best_sad, best_mv_x and best_mv_y.
  - If at the last position (+P,+P), go to DONE. Otherwise advance dx, wrapping to -P with dy+1, and go to LOAD_REF.
- DONE:
  - done=1 for 1 cycle and busy<=0.
  - Drain FIFO 1 before IDLE: issue 256 rd-only cycles, then assert done. The next start then sees empty FIFOs.

Arithmetic and latency:
- Arithmetic is unsigned 8-bit abs diff; sad_acc is 16 bits, max 65280, with no overflow possible.
- start is ignored while busy.
- Latency with no input stalls: 1 + 256 + N_POS*(256+257+1) + 256 + 1 cycles.

Decomposition:
Package sad_pkg:
- PIX_W=8, BLK_PIX=256, SAD_W=16, CNT_W=9.
- State enum for the FSM.

Sub-module sad_absdiff_acc:
- Inputs: a, b, en, clr.
- Output: registered 16-bit accumulator.
- Reusable by the later parallel-PE version.

Test Plan:
1. P=1, cur all 50; ref all 51 except position 4 (center) all 50 -> best_sad=0, mv=(0,0), done once, busy low after.
2. P=1, positions 2 and 6 both identical to cur, others +3 -> best_sad=0, mv=(dx=+1,dy=-1), i.e. the earlier position.
3. P=1, cur all 0, ref all 255 -> best_sad=65280, mv=(-1,-1), no wrap.
4. Random pixels with cur_valid/ref_valid toggling every other cycle -> SAD equals the software model. fifo_count_1=256 after each DRAIN; fifo_count_2=0 after each DRAIN.
5. Assert rst at DRAIN cycle 100 -> all outputs 0 next cycle and no done. A fresh start then completes correctly.
6. Preload 3 bytes into FIFO 2, then start -> err pulse 1 cycle, busy stays 0, no strobes.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared widths, FSM state encoding and pixel arithmetic for the SAD search block.
package sad_pkg;

  localparam int unsigned PIX_W   = 8;
  localparam int unsigned BLK_PIX = 256;
  localparam int unsigned SAD_W   = 16;
  localparam int unsigned CNT_W   = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CUR,
    ST_LOAD_REF,
    ST_DRAIN,
    ST_CMP,
    ST_DONE
  } state_e;

  // Unsigned absolute difference of two pixels.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_search_ctrl_if.sv
// Bundle of both byte-FIFO ports as seen by the search controller (master) and the FIFO pair (slave).
interface sad_search_ctrl_if;
  import sad_pkg::*;

  logic [PIX_W-1:0] fifo_din_1;
  logic             fifo_wr_1;
  logic             fifo_rd_1;
  logic [PIX_W-1:0] fifo_dout_1;
  logic [CNT_W-1:0] fifo_count_1;

  logic [PIX_W-1:0] fifo_din_2;
  logic             fifo_wr_2;
  logic             fifo_rd_2;
  logic [PIX_W-1:0] fifo_dout_2;
  logic [CNT_W-1:0] fifo_count_2;

  modport master (
    output fifo_din_1, fifo_wr_1, fifo_rd_1,
    output fifo_din_2, fifo_wr_2, fifo_rd_2,
    input  fifo_dout_1, fifo_count_1,
    input  fifo_dout_2, fifo_count_2
  );

  modport slave (
    input  fifo_din_1, fifo_wr_1, fifo_rd_1,
    input  fifo_din_2, fifo_wr_2, fifo_rd_2,
    output fifo_dout_1, fifo_count_1,
    output fifo_dout_2, fifo_count_2
  );

endinterface

// File: rtl/sad_absdiff_acc.sv
// Absolute-difference accumulator: one pixel pair per enabled cycle into a 16-bit sum.
module sad_absdiff_acc
  import sad_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [SAD_W-1:0] o_acc
);

  logic [PIX_W-1:0] w_diff;
  logic [SAD_W-1:0] r_acc;

  assign w_diff = abs_diff(i_a, i_b);

  // Clear has priority; a full 256-pixel block tops out at 65280 so no overflow guard is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + SAD_W'(w_diff);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search SAD sequencer: loads the current block once, then per candidate loads the
// reference block, drains both FIFOs in lockstep while recirculating current pixels,
// and keeps the earliest minimum SAD with its motion vector.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int unsigned P       = 1,
  parameter int unsigned BLK_PIX = sad_pkg::BLK_PIX,
  parameter int unsigned MV_W    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic [PIX_W-1:0]       cur_pix,
  input  logic                   cur_valid,
  output logic                   cur_ready,
  input  logic [PIX_W-1:0]       ref_pix,
  input  logic                   ref_valid,
  output logic                   ref_ready,
  sad_search_ctrl_if.master      fifo,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_mv_x,
  output logic signed [MV_W-1:0] best_mv_y
);

  localparam logic [CNT_W-1:0]       LAST_PIX = CNT_W'(BLK_PIX - 1);
  localparam logic [CNT_W-1:0]       TAIL     = CNT_W'(BLK_PIX);
  localparam logic signed [MV_W-1:0] POS_MAX  = MV_W'(P);
  localparam logic signed [MV_W-1:0] POS_MIN  = -POS_MAX;

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rd_q;
  logic signed [MV_W-1:0] r_dx;
  logic signed [MV_W-1:0] r_dy;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic [SAD_W-1:0]       r_best_sad;
  logic signed [MV_W-1:0] r_best_mv_x;
  logic signed [MV_W-1:0] r_best_mv_y;

  logic                   w_cur_ready;
  logic                   w_ref_ready;
  logic                   w_wr_1;
  logic                   w_wr_2;
  logic                   w_rd_1;
  logic                   w_rd_2;
  logic [PIX_W-1:0]       w_din_1;
  logic [PIX_W-1:0]       w_din_2;
  logic                   w_acc_en;
  logic                   w_acc_clr;
  logic                   w_fifos_empty;
  logic                   w_last_pos;
  logic [SAD_W-1:0]       w_acc;

  assign w_fifos_empty = (fifo.fifo_count_1 == '0) && (fifo.fifo_count_2 == '0);
  assign w_last_pos    = (r_dx == POS_MAX) && (r_dy == POS_MAX);

  // Accumulate only on the cycle after a lockstep read, when both registered FIFO outputs are valid.
  assign w_acc_en  = (r_state == ST_DRAIN) && r_rd_q;
  assign w_acc_clr = (r_state == ST_LOAD_REF) && ref_valid && (r_cnt == LAST_PIX);

  sad_absdiff_acc u_acc (
    .clk   (clk),
    .rst   (rst),
    .i_a   (fifo.fifo_dout_1),
    .i_b   (fifo.fifo_dout_2),
    .i_en  (w_acc_en),
    .i_clr (w_acc_clr),
    .o_acc (w_acc)
  );

  // Combinational stream handshakes and FIFO strobes, decoded from the registered state.
  always_comb begin
    w_cur_ready = 1'b0;
    w_ref_ready = 1'b0;
    w_wr_1      = 1'b0;
    w_wr_2      = 1'b0;
    w_rd_1      = 1'b0;
    w_rd_2      = 1'b0;
    w_din_1     = '0;
    w_din_2     = '0;
    case (r_state)
      ST_LOAD_CUR: begin
        w_cur_ready = 1'b1;
        w_wr_1      = cur_valid;
        w_din_1     = cur_pix;
      end
      ST_LOAD_REF: begin
        w_ref_ready = 1'b1;
        w_wr_2      = ref_valid;
        w_din_2     = ref_pix;
      end
      ST_DRAIN: begin
        w_rd_1 = (r_cnt < TAIL);
        w_rd_2 = (r_cnt < TAIL);
        w_wr_1 = r_rd_q;
        w_din_1 = r_rd_q ? fifo.fifo_dout_1 : '0;
      end
      ST_DONE: begin
        w_rd_1 = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Search sequencer with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rd_q      <= 1'b0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_best_sad  <= '0;
      r_best_mv_x <= '0;
      r_best_mv_y <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_rd_q <= w_rd_2;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_fifos_empty) begin
              r_best_sad <= '1;
              r_dx       <= POS_MIN;
              r_dy       <= POS_MIN;
              r_cnt      <= '0;
              r_busy     <= 1'b1;
              r_state    <= ST_LOAD_CUR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_LOAD_CUR: begin
          if (cur_valid) begin
            if (r_cnt == LAST_PIX) begin
              r_cnt   <= '0;
              r_state <= ST_LOAD_REF;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_LOAD_REF: begin
          if (ref_valid) begin
            if (r_cnt == LAST_PIX) begin
              r_cnt   <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // 256 read cycles plus one tail cycle for the last registered read data.
          if (r_cnt == TAIL) begin
            r_cnt   <= '0;
            r_state <= ST_CMP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_CMP: begin
          // Strict compare keeps the earliest position on ties.
          if (w_acc < r_best_sad) begin
            r_best_sad  <= w_acc;
            r_best_mv_x <= r_dx;
            r_best_mv_y <= r_dy;
          end
          r_cnt <= '0;
          if (w_last_pos) begin
            r_state <= ST_DONE;
          end else begin
            if (r_dx == POS_MAX) begin
              r_dx <= POS_MIN;
              r_dy <= r_dy + MV_W'(1);
            end else begin
              r_dx <= r_dx + MV_W'(1);
            end
            r_state <= ST_LOAD_REF;
          end
        end
        ST_DONE: begin
          // Empty FIFO 1 so the next start sees both FIFOs clear.
          if (r_cnt == LAST_PIX) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign best_sad  = r_best_sad;
  assign best_mv_x = r_best_mv_x;
  assign best_mv_y = r_best_mv_y;
  assign cur_ready = w_cur_ready;
  assign ref_ready = w_ref_ready;

  assign fifo.fifo_din_1 = w_din_1;
  assign fifo.fifo_wr_1  = w_wr_1;
  assign fifo.fifo_rd_1  = w_rd_1;
  assign fifo.fifo_din_2 = w_din_2;
  assign fifo.fifo_wr_2  = w_wr_2;
  assign fifo.fifo_rd_2  = w_rd_2;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl with a behavioural model of the two byte FIFOs.
module tb_sad_search_ctrl;
  import sad_pkg::*;

  localparam int unsigned P      = 1;
  localparam int unsigned MV_W   = 5;
  localparam int          NPIX   = 256;
  localparam int          N_POS  = (2 * P + 1) * (2 * P + 1);
  localparam int          TMO    = 20000;
  localparam int          LAT_NS = 1 + 256 + N_POS * (256 + 257 + 1) + 256 + 1;
  localparam logic [4:0]  MV_M1  = 5'b11111;
  localparam logic [4:0]  MV_0   = 5'd0;
  localparam logic [4:0]  MV_P1  = 5'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, err;
  logic [7:0] cur_pix = '0;
  logic cur_valid = 1'b0;
  logic cur_ready;
  logic [7:0] ref_pix = '0;
  logic ref_valid = 1'b0;
  logic ref_ready;
  logic [15:0] best_sad;
  logic [4:0] best_mv_x, best_mv_y;

  logic tb_wr_2 = 1'b0;
  logic [7:0] tb_din_2 = '0;

  logic [7:0] cur_mem [NPIX];
  logic [7:0] ref_mem [N_POS*NPIX];

  int n_total = 0;
  int n_bad = 0;
  bit fifo_fault = 1'b0;

  sad_search_ctrl_if fif ();

  sad_search_ctrl #(.P(P), .BLK_PIX(256), .MV_W(MV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cur_pix   (cur_pix),
    .cur_valid (cur_valid),
    .cur_ready (cur_ready),
    .ref_pix   (ref_pix),
    .ref_valid (ref_valid),
    .ref_ready (ref_ready),
    .fifo      (fif),
    .best_sad  (best_sad),
    .best_mv_x (best_mv_x),
    .best_mv_y (best_mv_y)
  );

  always #5 clk = ~clk;

  // Two 256-deep FIFOs with registered read data, sharing the controller reset.
  logic [7:0] f1_mem [NPIX];
  logic [7:0] f2_mem [NPIX];
  logic [7:0] f1_wp, f1_rp, f2_wp, f2_rp;
  logic       w2;
  logic [7:0] d2;
  assign w2 = fif.fifo_wr_2 | tb_wr_2;
  assign d2 = tb_wr_2 ? tb_din_2 : fif.fifo_din_2;

  always @(posedge clk) begin
    if (rst) begin
      f1_wp <= '0; f1_rp <= '0; f2_wp <= '0; f2_rp <= '0;
      fif.fifo_count_1 <= '0; fif.fifo_count_2 <= '0;
      fif.fifo_dout_1 <= '0; fif.fifo_dout_2 <= '0;
    end else begin
      if (fif.fifo_rd_1 && fif.fifo_count_1 == 0) fifo_fault <= 1'b1;
      if (fif.fifo_rd_2 && fif.fifo_count_2 == 0) fifo_fault <= 1'b1;
      if (fif.fifo_wr_1 && !fif.fifo_rd_1 && fif.fifo_count_1 == 9'd256) fifo_fault <= 1'b1;
      if (w2 && !fif.fifo_rd_2 && fif.fifo_count_2 == 9'd256) fifo_fault <= 1'b1;
      if (fif.fifo_wr_1) begin f1_mem[f1_wp] <= fif.fifo_din_1; f1_wp <= f1_wp + 8'd1; end
      if (fif.fifo_rd_1) begin fif.fifo_dout_1 <= f1_mem[f1_rp]; f1_rp <= f1_rp + 8'd1; end
      if (w2) begin f2_mem[f2_wp] <= d2; f2_wp <= f2_wp + 8'd1; end
      if (fif.fifo_rd_2) begin fif.fifo_dout_2 <= f2_mem[f2_rp]; f2_rp <= f2_rp + 8'd1; end
      fif.fifo_count_1 <= fif.fifo_count_1 + 9'(fif.fifo_wr_1) - 9'(fif.fifo_rd_1);
      fif.fifo_count_2 <= fif.fifo_count_2 + 9'(w2) - 9'(fif.fifo_rd_2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_cur_ready"}, 32'(cur_ready), 0);
    check({tag, "_ref_ready"}, 32'(ref_ready), 0);
    check({tag, "_strobes"}, 32'({fif.fifo_wr_1, fif.fifo_rd_1, fif.fifo_wr_2, fif.fifo_rd_2}), 0);
    check({tag, "_din"}, 32'({fif.fifo_din_1, fif.fifo_din_2}), 0);
    check({tag, "_best_sad"}, 32'(best_sad), 0);
    check({tag, "_mv"}, 32'({best_mv_x, best_mv_y}), 0);
  endtask

  // Runs one search from a post-edge point; optionally asserts rst in DRAIN cycle abort_at of the first position.
  task automatic run_search(input bit stall, input int abort_at, output int lat, output int n_done);
    int ci, ri, cyc, dcyc;
    bit hs_c, hs_r, prev_rd2, chk_next, fin;
    ci = 0; ri = 0; cyc = 0; dcyc = -1; lat = 0; n_done = 0;
    prev_rd2 = 1'b0; chk_next = 1'b0; fin = 1'b0;
    start = 1'b1;
    cur_valid = 1'b1;
    ref_valid = !stall;
    cur_pix = cur_mem[0];
    ref_pix = ref_mem[0];
    while (!fin && cyc < TMO) begin
      @(negedge clk);
      cyc++;
      hs_c = cur_ready && cur_valid;
      hs_r = ref_ready && ref_valid;
      if (chk_next) begin
        check("drain_count_1", 32'(fif.fifo_count_1), 256);
        check("drain_count_2", 32'(fif.fifo_count_2), 0);
        chk_next = 1'b0;
      end
      if (prev_rd2 && !fif.fifo_rd_2) chk_next = 1'b1;
      prev_rd2 = fif.fifo_rd_2;
      if (fif.fifo_rd_2) dcyc++;
      if (done) begin
        n_done++;
        lat = cyc;
        fin = 1'b1;
      end
      if (abort_at >= 0 && dcyc == abort_at) begin
        rst = 1'b1;
        fin = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (hs_c) ci++;
      if (hs_r) ri++;
      cur_valid = !stall || ((cyc % 2) == 0);
      ref_valid = !stall || ((cyc % 2) == 1);
      cur_pix = cur_mem[ci % NPIX];
      ref_pix = (ri < N_POS * NPIX) ? ref_mem[ri] : 8'h00;
    end
    cur_valid = 1'b0;
    ref_valid = 1'b0;
  endtask

  task automatic post_watch(input string tag, input int ncyc);
    int extra;
    extra = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, "_extra_done"}, 32'(extra), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
    check({tag, "_fifo1_empty"}, 32'(fif.fifo_count_1), 0);
    tick();
  endtask

  function automatic void sw_model(output int bs, output logic [4:0] mx, output logic [4:0] my);
    int s;
    bs = 32'hFFFF;
    mx = '0;
    my = '0;
    for (int p = 0; p < N_POS; p++) begin
      s = 0;
      for (int i = 0; i < NPIX; i++) begin
        s += (cur_mem[i] >= ref_mem[p*NPIX+i]) ? int'(cur_mem[i] - ref_mem[p*NPIX+i])
                                               : int'(ref_mem[p*NPIX+i] - cur_mem[i]);
      end
      if (s < bs) begin
        bs = s;
        mx = 5'((p % 3) - 1);
        my = 5'((p / 3) - 1);
      end
    end
  endfunction

  task automatic load_t1();
    for (int i = 0; i < NPIX; i++) cur_mem[i] = 8'd50;
    for (int p = 0; p < N_POS; p++)
      for (int i = 0; i < NPIX; i++) ref_mem[p*NPIX+i] = (p == 4) ? 8'd50 : 8'd51;
  endtask

  initial begin
    int lat, nd, exp_sad;
    logic [4:0] ex, ey;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    tick();

    // 1: only the centre candidate matches
    load_t1();
    run_search(1'b0, -1, lat, nd);
    check("t1_done", 32'(nd), 1);
    check("t1_latency", 32'(lat), 32'(LAT_NS));
    check("t1_sad", 32'(best_sad), 0);
    check("t1_mv_x", 32'(best_mv_x), 32'(MV_0));
    check("t1_mv_y", 32'(best_mv_y), 32'(MV_0));
    post_watch("t1", 4);

    // 2: tie between positions 2 and 6, earlier one wins
    for (int i = 0; i < NPIX; i++) cur_mem[i] = 8'(i);
    for (int p = 0; p < N_POS; p++)
      for (int i = 0; i < NPIX; i++) ref_mem[p*NPIX+i] = (p == 2 || p == 6) ? 8'(i) : 8'(i + 3);
    run_search(1'b0, -1, lat, nd);
    check("t2_done", 32'(nd), 1);
    check("t2_sad", 32'(best_sad), 0);
    check("t2_mv_x", 32'(best_mv_x), 32'(MV_P1));
    check("t2_mv_y", 32'(best_mv_y), 32'(MV_M1));
    post_watch("t2", 4);

    // 3: maximum SAD everywhere, no accumulator wrap
    for (int i = 0; i < NPIX; i++) cur_mem[i] = 8'd0;
    for (int i = 0; i < N_POS * NPIX; i++) ref_mem[i] = 8'd255;
    run_search(1'b0, -1, lat, nd);
    check("t3_done", 32'(nd), 1);
    check("t3_latency", 32'(lat), 32'(LAT_NS));
    check("t3_sad", 32'(best_sad), 65280);
    check("t3_mv_x", 32'(best_mv_x), 32'(MV_M1));
    check("t3_mv_y", 32'(best_mv_y), 32'(MV_M1));
    post_watch("t3", 4);

    // 4: random pixels with valids toggling every other cycle
    for (int i = 0; i < NPIX; i++) cur_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < N_POS * NPIX; i++) ref_mem[i] = 8'($urandom_range(0, 255));
    sw_model(exp_sad, ex, ey);
    run_search(1'b1, -1, lat, nd);
    check("t4_done", 32'(nd), 1);
    check("t4_sad", 32'(best_sad), 32'(exp_sad));
    check("t4_mv_x", 32'(best_mv_x), 32'(ex));
    check("t4_mv_y", 32'(best_mv_y), 32'(ey));
    post_watch("t4", 4);

    // 5: reset in DRAIN cycle 100 aborts silently, then a fresh search completes
    load_t1();
    run_search(1'b0, 100, lat, nd);
    rst = 1'b0;
    @(negedge clk);
    check_zero("t5_abort");
    check("t5_abort_done", 32'(nd), 0);
    check("t5_fifo_counts", 32'({fif.fifo_count_1, fif.fifo_count_2}), 0);
    post_watch("t5_abort", 10);
    run_search(1'b0, -1, lat, nd);
    check("t5_done", 32'(nd), 1);
    check("t5_latency", 32'(lat), 32'(LAT_NS));
    check("t5_sad", 32'(best_sad), 0);
    check("t5_mv", 32'({best_mv_x, best_mv_y}), 32'({MV_0, MV_0}));
    post_watch("t5", 4);

    // 6: start with FIFO 2 not empty raises err only
    tb_wr_2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tb_din_2 = 8'(k + 7);
      tick();
    end
    tb_wr_2 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("t6_err", 32'(err), 1);
    check("t6_busy", 32'(busy), 0);
    check("t6_strobes", 32'({fif.fifo_wr_1, fif.fifo_rd_1, fif.fifo_wr_2, fif.fifo_rd_2}), 0);
    tick();
    @(negedge clk);
    check("t6_err_pulse", 32'(err), 0);
    check("t6_busy2", 32'(busy), 0);
    check("t6_ready", 32'({cur_ready, ref_ready}), 0);
    check("t6_count_2", 32'(fif.fifo_count_2), 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    check("fifo_model_fault", 32'(fifo_fault), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
